// File: rtl/uart_buffered_tx.sv
// uart_buffered_tx
//   Buffered 8N1 UART transmitter. Bytes pushed on i_wr_en go into a small
//   FIFO; the FSM pops them and serializes each one LSB first on o_tx_line.
//   Timing comes from a 16x oversampled baud-tick divider. While the FIFO
//   still holds data, frames follow each other with no idle gap.
//
//   Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between
//   the data bits and the stop bit. Without it, frames are plain 8N1.
//
// Ports
//   i_clk      system clock
//   i_reset    synchronous, active-high reset
//   i_wr_en    push strobe, one byte per cycle while high
//   i_wr_data  byte to push
//   o_full     FIFO holds FIFO_DEPTH entries (registered)
//   o_empty    FIFO holds no entries (registered)
//   o_tx_line  serial output, idles high (registered)
//   o_busy     a frame is in progress
//   o_done     one-cycle pulse on the last cycle of each stop bit (registered)
module uart_buffered_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 9600,
  parameter int DATA_BIT     = 8,
  parameter int STOPBIT_TICK = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_en,
  input  logic [DATA_BIT-1:0] i_wr_data,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_tx_line,
  output logic                o_busy,
  output logic                o_done
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * STOPBIT_TICK);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int TW      = $clog2(STOPBIT_TICK + 1);
  localparam int BW      = $clog2(DATA_BIT + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_BIT-1:0] shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                tx_q, tx_d, done_q, done_d;
  logic [DATA_BIT-1:0] mem_q [FIFO_DEPTH];

  logic baud_tick, bit_end, have_data, pop, push;

  always_comb begin
    baud_tick = (div_q == DW'(DIV - 1));
    bit_end   = baud_tick && (tick_q == TW'(STOPBIT_TICK - 1));
    have_data = (count_q != '0);

    state_d = state_q;
    div_d   = baud_tick ? '0 : div_q + DW'(1);
    tick_d  = bit_end ? '0 : (baud_tick ? tick_q + TW'(1) : tick_q);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        // Divider parked at zero so the first bit is a full STOPBIT_TICK*DIV.
        div_d  = '0;
        tick_d = '0;
        if (have_data) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          par_d   = ^mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(DATA_BIT - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (have_data) begin
            // Reload straight into START: divider and tick counter wrap to
            // zero on this cycle, so the next start bit is full length.
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            par_d   = ^mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so o_tx_line is a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase

    // Look one cycle ahead so the registered pulse lands on the last stop cycle.
    done_d = (state_d == STOP) && (tick_d == TW'(STOPBIT_TICK - 1)) &&
             (div_d == DW'(DIV - 1));

    // A full FIFO still takes a byte when a pop frees a slot the same cycle.
    push     = i_wr_en && ((count_q != CW'(FIFO_DEPTH)) || pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: the cleared pointers make old contents unreachable.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_tx_line = tx_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;

endmodule

// File: tb/tb_uart_buffered_tx.sv
module tb_uart_buffered_tx;
  localparam int BIT_CLKS = 160;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT_CLKS;

  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx, busy, done;

  int errors = 0, checks = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, busy_fall_cyc = -1, low_cnt = 0;
  int ferr = 0;
  logic       last_par = 1'b0;
  logic [7:0] rx_q[$];
  int         st_q[$];

  uart_buffered_tx #(
    .CLK_FREQ(1600000), .BAUD(10000), .DATA_BIT(8), .STOPBIT_TICK(16), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_tx_line(tx), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse / level monitor
  initial begin : mon
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
      if (tx === 1'b0) low_cnt++;
      busy_prev = busy;
    end
  end

  // Independent receiver: mid-bit sampling from the falling start edge.
  initial begin : decoder
    logic prev, ab;
    logic [NBITS-1:0] bits;
    int s;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prev === 1'b1 && tx === 1'b0 && !rst) begin
        s = cyc; ab = 1'b0; bits = '0;
        for (int t = 1; t <= BIT_CLKS/2 + BIT_CLKS*(NBITS-1); t++) begin
          @(posedge clk); #1;
          if (rst) ab = 1'b1;
          if (t >= BIT_CLKS/2 && ((t - BIT_CLKS/2) % BIT_CLKS) == 0)
            bits[(t - BIT_CLKS/2) / BIT_CLKS] = tx;
        end
        if (!ab) begin
          if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) ferr++;
          rx_q.push_back(bits[8:1]);
          st_q.push_back(s);
`ifdef UART_TX_PARITY_EN
          last_par = bits[9];
`endif
        end
      end
      prev = tx;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int t = 0; t < budget && rx_q.size() < n; t++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    rst = 1'b0; tick();
  endtask

  task automatic test_single();
    int b_rx, b_done;
    b_rx = rx_q.size(); b_done = done_cnt;
    wr_data = 8'h48; wr_en = 1'b1; tick(); wr_en = 1'b0;  // cycle N+1
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL single_n1_tx: got %b want 1", tx); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_n1_empty: got %b want 0", empty); end
    tick();                                                 // cycle N+2
    checks++; if (tx !== 1'b0)    begin errors++; $display("FAIL single_n2_tx: got %b want 0", tx); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL single_n2_busy: got %b want 1", busy); end
    wait_rx(b_rx + 1, 2 * FRAME);
    repeat (BIT_CLKS) tick();
    checks++; if (rx_q.size() !== b_rx + 1) begin errors++; $display("FAIL single_count: got %0d want %0d", rx_q.size(), b_rx + 1); end
    if (rx_q.size() > b_rx) begin
      checks++; if (rx_q[b_rx] !== 8'h48) begin errors++; $display("FAIL single_data: got %h want 48", rx_q[b_rx]); end
      checks++; if (done_cyc - st_q[b_rx] + 1 !== FRAME) begin errors++; $display("FAIL single_len: got %0d want %0d", done_cyc - st_q[b_rx] + 1, FRAME); end
    end
    checks++; if (done_cnt - b_done !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt - b_done); end
    checks++; if (busy_fall_cyc !== done_cyc + 1) begin errors++; $display("FAIL single_busy_fall: got %0d want %0d", busy_fall_cyc, done_cyc + 1); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL single_framing: got %0d want 0", ferr); end
  endtask

  task automatic test_hello();
    logic [7:0] msg [5];
    int b_rx, b_done;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    b_rx = rx_q.size(); b_done = done_cnt;
    for (int i = 0; i < 5; i++) begin wr_data = msg[i]; wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    wait_rx(b_rx + 5, 6 * FRAME);
    repeat (BIT_CLKS) tick();
    checks++; if (rx_q.size() !== b_rx + 5) begin errors++; $display("FAIL hello_count: got %0d want %0d", rx_q.size(), b_rx + 5); end
    if (rx_q.size() >= b_rx + 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (rx_q[b_rx+i] !== msg[i]) begin errors++; $display("FAIL hello_data%0d: got %h want %h", i, rx_q[b_rx+i], msg[i]); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++; if (st_q[b_rx+i] - st_q[b_rx+i-1] !== FRAME) begin errors++; $display("FAIL hello_gap%0d: got %0d want %0d", i, st_q[b_rx+i] - st_q[b_rx+i-1], FRAME); end
      end
    end
    checks++; if (done_cnt - b_done !== 5) begin errors++; $display("FAIL hello_done: got %0d want 5", done_cnt - b_done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hello_empty: got %b want 1", empty); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL hello_framing: got %0d want 0", ferr); end
  endtask

  task automatic test_overflow();
    int b_rx;
    b_rx = rx_q.size();
    for (int i = 0; i < 10; i++) begin wr_data = 8'h10 + 8'(i); wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
    wait_rx(b_rx + 9, 10 * FRAME);
    repeat (FRAME + 50) tick();
    checks++; if (rx_q.size() !== b_rx + 9) begin errors++; $display("FAIL ovf_count: got %0d want %0d", rx_q.size(), b_rx + 9); end
    if (rx_q.size() >= b_rx + 9) begin
      for (int i = 0; i < 9; i++) begin
        checks++; if (rx_q[b_rx+i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, rx_q[b_rx+i], 8'h10 + 8'(i)); end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_pop();
    int b_rx, n;
    b_rx = rx_q.size();
    for (int i = 0; i < 9; i++) begin wr_data = 8'h20 + 8'(i); wr_en = 1'b1; tick(); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpop_full_pre: got %b want 1", full); end
    // Hold the strobe through the first STOP->START pop.
    wr_data = 8'hC3;
    for (int t = 0; t < 2 * FRAME; t++) begin tick(); if (done === 1'b1) break; end
    tick(); wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpop_full_post: got %b want 1", full); end
    wait_rx(b_rx + 10, 11 * FRAME);
    repeat (FRAME + 50) tick();
    n = rx_q.size();
    checks++; if (n !== b_rx + 10) begin errors++; $display("FAIL fpop_count: got %0d want %0d", n, b_rx + 10); end
    if (n >= b_rx + 10) begin
      checks++; if (rx_q[b_rx+8] !== 8'h28) begin errors++; $display("FAIL fpop_data8: got %h want 28", rx_q[b_rx+8]); end
      checks++; if (rx_q[b_rx+9] !== 8'hC3) begin errors++; $display("FAIL fpop_data9: got %h want c3", rx_q[b_rx+9]); end
    end
  endtask

  task automatic test_reset_mid();
    int b_rx, b_done, b_low;
    logic [7:0] bytes [4];
    bytes = '{8'hA5, 8'h01, 8'h02, 8'h03};
    b_rx = rx_q.size(); b_done = done_cnt;
    for (int i = 0; i < 4; i++) begin wr_data = bytes[i]; wr_en = 1'b1; tick(); end
    wr_en = 1'b0;
    repeat (BIT_CLKS + 400) tick();   // inside the DATA bits of A5
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    rst = 1'b1; tick();
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rmid_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    rst = 1'b0; b_low = low_cnt;
    repeat (2 * FRAME) tick();
    checks++; if (low_cnt !== b_low) begin errors++; $display("FAIL rmid_no_frames: got %0d low cycles want 0", low_cnt - b_low); end
    checks++; if (done_cnt !== b_done) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt - b_done); end
    checks++; if (rx_q.size() !== b_rx) begin errors++; $display("FAIL rmid_rx: got %0d want %0d", rx_q.size(), b_rx); end
  endtask

  task automatic test_parity();
    logic [7:0] vals [2];
    logic       pexp [2];
    int b_rx;
    vals = '{8'h07, 8'h03};
    pexp = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      b_rx = rx_q.size();
      wr_data = vals[k]; wr_en = 1'b1; tick(); wr_en = 1'b0;
      wait_rx(b_rx + 1, 2 * FRAME);
      repeat (BIT_CLKS) tick();
      checks++; if (rx_q.size() !== b_rx + 1) begin errors++; $display("FAIL par_count%0d: got %0d want %0d", k, rx_q.size(), b_rx + 1); end
      if (rx_q.size() > b_rx) begin
        checks++; if (rx_q[b_rx] !== vals[k]) begin errors++; $display("FAIL par_data%0d: got %h want %h", k, rx_q[b_rx], vals[k]); end
        checks++; if (done_cyc - st_q[b_rx] + 1 !== FRAME) begin errors++; $display("FAIL par_len%0d: got %0d want %0d", k, done_cyc - st_q[b_rx] + 1, FRAME); end
      end
`ifdef UART_TX_PARITY_EN
      checks++; if (last_par !== pexp[k]) begin errors++; $display("FAIL par_bit%0d: got %b want %b", k, last_par, pexp[k]); end
`else
      if (pexp[k] === 1'b1) last_par = 1'b1;  // parity unused in this build
`endif
    end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL par_framing: got %0d want 0", ferr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hello();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
